// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared command/state types and default servo widths for the colour sorter
package sort_pkg;

    typedef enum logic [1:0] {
        CMD_GO    = 2'd0,
        CMD_RED   = 2'd1,
        CMD_GREEN = 2'd2,
        CMD_BLUE  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POSITION = 2'd1,
        DISPENSE = 2'd2
    } state_t;

    localparam logic [16:0] W_RED_DEF   = 17'd73000;
    localparam logic [16:0] W_GREEN_DEF = 17'd95000;
    localparam logic [16:0] W_BLUE_DEF  = 17'd50000;
    localparam logic [16:0] W_LEFT_DEF  = 17'd50000;
    localparam logic [16:0] W_RIGHT_DEF = 17'd100000;

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running servo frame counter with first/last tick strobes
module servo_frame_timer #(
    parameter int FRAME_TICKS = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_start,
    output logic frame_last
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign frame_start = (cnt == '0);
    assign frame_last  = (cnt == LAST);

endmodule

// File: rtl/sort_sequencer.sv
// rtl/sort_sequencer.sv - frame-aligned servo command scheduler; SORT_COALESCE_EN merges colour requests at the queue tail
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int          FRAME_TICKS = 1000000,
    parameter int          POS_FRAMES  = 50,
    parameter int          DISP_FRAMES = 100,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [16:0] W_RED       = W_RED_DEF,
    parameter logic [16:0] W_GREEN     = W_GREEN_DEF,
    parameter logic [16:0] W_BLUE      = W_BLUE_DEF,
    parameter logic [16:0] W_LEFT      = W_LEFT_DEF,
    parameter logic [16:0] W_RIGHT     = W_RIGHT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_red,
    input  logic        req_green,
    input  logic        req_blue,
    input  logic        req_go,
    output logic        pos_en,
    output logic [16:0] pos_width,
    output logic        disp_en,
    output logic [16:0] disp_width,
    output logic        frame_start,
    output logic        busy,
    output logic        fifo_full,
    output logic        drop_err,
    output logic [1:0]  state_dbg
);

    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW     = PW + 1;
    localparam int HOLD_MAX = (POS_FRAMES > DISP_FRAMES) ? POS_FRAMES : DISP_FRAMES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    logic frame_last;

    servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    // Bit order {go, blue, green, red} so the lowest set bit is the winning request.
    logic [3:0] sync1, sync2, prev, rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {req_go, req_blue, req_green, req_red};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    cmd_t       sel;
    logic       any_rise, multi_rise;

    always_comb begin
        sel = CMD_GO;
        if (rise[0])      sel = CMD_RED;
        else if (rise[1]) sel = CMD_GREEN;
        else if (rise[2]) sel = CMD_BLUE;
    end

    assign any_rise   = |rise;
    assign multi_rise = (rise & (rise - 4'd1)) != 4'd0;

    cmd_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    cmd_t            head, tail;
    logic            fifo_empty, pop, do_push, coalesce, drop;

    state_t          state;
    logic [HW-1:0]   hold;
    logic            dir_right, done, next_dir;

    assign head       = mem[rd_ptr];
    assign tail       = mem[wr_ptr - 1'b1];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNTW'(FIFO_DEPTH));

    assign done = frame_last &&
                  ((state == POSITION && hold == HW'(POS_FRAMES)) ||
                   (state == DISPENSE && hold == HW'(DISP_FRAMES)));
    // Popping on the last tick means the new command starts exactly on frame count 0.
    assign pop  = frame_last && !fifo_empty && (state == IDLE || done);

`ifdef SORT_COALESCE_EN
    // A tail entry that is also the head being popped this cycle is no longer mergeable.
    assign coalesce = any_rise && (sel != CMD_GO) && !fifo_empty && (tail != CMD_GO) &&
                      !(pop && count == CNTW'(1));
`else
    assign coalesce = 1'b0;
`endif

    assign do_push = any_rise && !coalesce && (!fifo_full || pop);
    assign drop    = multi_rise || (any_rise && !coalesce && !do_push);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sel;
        end else if (coalesce) begin
            mem[wr_ptr - 1'b1] <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + CNTW'(do_push) - CNTW'(pop);
            if (drop)    drop_err <= 1'b1;
        end
    end

    assign next_dir = (done && state == DISPENSE) ? ~dir_right : dir_right;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pos_en     <= 1'b0;
            disp_en    <= 1'b0;
            pos_width  <= '0;
            disp_width <= '0;
            dir_right  <= 1'b0;
            hold       <= '0;
        end else begin
            if (state != IDLE && frame_start) begin
                hold <= hold + 1'b1;
            end
            if (done) begin
                state     <= IDLE;
                pos_en    <= 1'b0;
                disp_en   <= 1'b0;
                dir_right <= next_dir;
            end
            if (pop) begin
                hold <= '0;
                if (head == CMD_GO) begin
                    state      <= DISPENSE;
                    disp_en    <= 1'b1;
                    disp_width <= next_dir ? W_RIGHT : W_LEFT;
                end else begin
                    state  <= POSITION;
                    pos_en <= 1'b1;
                    case (head)
                        CMD_RED:   pos_width <= W_RED;
                        CMD_GREEN: pos_width <= W_GREEN;
                        default:   pos_width <= W_BLUE;
                    endcase
                end
            end
        end
    end

    assign busy      = (state != IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_sort_sequencer.sv
// tb/tb_sort_sequencer.sv - scoreboard bench for sort_sequencer with short frames
module tb_sort_sequencer;

    localparam int FT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  reqs = 4'b0;
    logic        pos_en, disp_en, frame_start, busy, fifo_full, drop_err;
    logic [16:0] pos_width, disp_width;
    logic [1:0]  state_dbg;

    sort_sequencer #(
        .FRAME_TICKS (FT),
        .POS_FRAMES  (2),
        .DISP_FRAMES (3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_red     (reqs[0]),
        .req_green   (reqs[1]),
        .req_blue    (reqs[2]),
        .req_go      (reqs[3]),
        .pos_en      (pos_en),
        .pos_width   (pos_width),
        .disp_en     (disp_en),
        .disp_width  (disp_width),
        .frame_start (frame_start),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .drop_err    (drop_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int disp;
        int width;
        int dur;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   act[2];
    int   st[2];
    int   wd[2];

    localparam logic [3:0] RED = 4'b0001, GREEN = 4'b0010, BLUE = 4'b0100, GO = 4'b1000;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_seg(input int disp, input int width, input int dur);
        exp_t e;
        e.disp = disp; e.width = width; e.dur = dur;
        sb.push_back(e);
    endtask

    task automatic end_seg(input int ch);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_segment: channel %0d width %0d ran with nothing expected", ch, wd[ch]);
        end else begin
            e = sb.pop_front();
            check("seg_channel", ch, e.disp);
            check("seg_width", wd[ch], e.width);
            check("seg_duration", cyc - st[ch], e.dur);
        end
    endtask

    task automatic seg_step(input int ch, input logic en, input int w);
        if (act[ch] != 0 && (!en || w != wd[ch])) begin
            end_seg(ch);
            act[ch] = 0;
        end
        if (en && act[ch] == 0) begin
            act[ch] = 1;
            st[ch]  = cyc;
            wd[ch]  = w;
            check("seg_frame_aligned", int'(frame_start), 1);
        end
    endtask

    // Monitor: each contiguous enable run with a constant width is one executed command.
    initial begin
        act[0] = 0; act[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            seg_step(0, pos_en, int'(pos_width));
            seg_step(1, disp_en, int'(disp_width));
        end
    end

    task automatic pulse(input logic [3:0] m);
        @(negedge clk);
        reqs = m;
        repeat (2) @(negedge clk);
        reqs = 4'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy && !pos_en && !disp_en) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, %0d expected segments pending", name, budget, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic align_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        do_reset();
        @(negedge clk);
        check("reset_pos_en", int'(pos_en), 0);
        check("reset_disp_en", int'(disp_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_fifo_full", int'(fifo_full), 0);
        check("reset_drop_err", int'(drop_err), 0);
        check("reset_state", int'(state_dbg), 0);
        check("reset_pos_width", int'(pos_width), 0);

        // single red move
        expect_seg(0, 73000, 200);
        pulse(RED);
        check("red_busy_queued", int'(busy), 1);
        wait_idle(1000, "red");
        check("red_busy_after", int'(busy), 0);
        check("red_pos_width_held", int'(pos_width), 73000);

        // two dispense strokes back-to-back, alternating direction
        expect_seg(1, 50000, 300);
        expect_seg(1, 100000, 300);
        pulse(GO);
        pulse(GO);
        wait_idle(2000, "go_pair");
        check("go_pair_no_drop", int'(drop_err), 0);

        // coincident blue and go: blue wins, go dropped
        expect_seg(0, 50000, 200);
        pulse(BLUE | GO);
        check("coincident_drop_err", int'(drop_err), 1);
        wait_idle(1000, "coincident");

        // overflow: six go edges, four accepted
        do_reset();
        expect_seg(1, 50000, 300);
        expect_seg(1, 100000, 300);
        expect_seg(1, 50000, 300);
        expect_seg(1, 100000, 300);
        check("overflow_pre_drop", int'(drop_err), 0);
        for (int i = 0; i < 6; i++) pulse(GO);
        check("overflow_fifo_full", int'(fifo_full), 1);
        check("overflow_drop_err", int'(drop_err), 1);
        check("overflow_idle_waiting", int'(state_dbg), 0);
        wait_idle(3000, "overflow");
        repeat (500) @(negedge clk);
        check("overflow_drained_busy", int'(busy), 0);

        // reset mid-position
        do_reset();
        expect_seg(0, 73000, 51);
        pulse(RED);
        n = 0;
        while (!pos_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("midreset_pos_started", int'(pos_en), 1);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_pos_en", int'(pos_en), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_state", int'(state_dbg), 0);
        rst_n = 1'b1;
        expect_seg(1, 50000, 300);
        pulse(GO);
        wait_idle(1000, "midreset_go");

        // colour tail merge (or plain queueing when merging is disabled)
        do_reset();
        expect_seg(1, 50000, 300);
`ifdef SORT_COALESCE_EN
        expect_seg(0, 95000, 200);
`else
        expect_seg(0, 73000, 200);
        expect_seg(0, 95000, 200);
`endif
        align_frame();
        pulse(GO);
        pulse(RED);
        pulse(GREEN);
        check("merge_no_drop", int'(drop_err), 0);
        wait_idle(3000, "merge");

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
